btn_debounce_fsm: RTL and testbench

//  Tick-driven push-button debouncer. Sits directly downstream of the 1 kHz tick generator.

---
 rtl/btn_pkg.sv | 15 +
 rtl/btn_sync.sv | 21 ++
 rtl/btn_debounce_fsm.sv | 144 ++++++++++++++
 tb/tb_btn_debounce_fsm.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and default constants for the tick-driven button debouncer.
// The default build omits the long-press feature; see btn_debounce_fsm.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam int DEB_TICKS_DEF  = 10;
  localparam int LONG_TICKS_DEF = 1000;

endpackage

// File: rtl/btn_sync.sv
// N-flop synchroniser for an asynchronous single-bit input.
// All stages reset to 0.
module btn_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[N-2:0], d};
  end

  assign q = ff[N-1];

endmodule

// File: rtl/btn_debounce_fsm.sv
// Tick-qualified button debouncer with registered level and edge pulses.
// Define LONG_PRESS_EN to build the long-press detector.
module btn_debounce_fsm
  import btn_pkg::*;
#(
  parameter int DEB_TICKS   = DEB_TICKS_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int LONG_TICKS  = LONG_TICKS_DEF
) (
  input  logic clk_100Mhz,
  input  logic rst,
  input  logic tick,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic long_press
);

  localparam int CW = $clog2(DEB_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_TICKS - 1);

  logic          s;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          level_n, press_n, release_n;

  btn_sync #(.N(SYNC_STAGES)) u_sync (
    .clk (clk_100Mhz),
    .rst (rst),
    .d   (btn_raw),
    .q   (s)
  );

  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      state       <= IDLE_LO;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      btn_level   <= level_n;
      btn_press   <= press_n;
      btn_release <= release_n;
    end
  end

  // A reverted input beats a coincident tick.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    level_n   = btn_level;
    press_n   = 1'b0;
    release_n = 1'b0;
    unique case (state)
      IDLE_LO: if (s) begin
        state_n = WAIT_HI;
        cnt_n   = '0;
      end
      WAIT_HI: begin
        if (!s) begin
          state_n = IDLE_LO;
          cnt_n   = '0;
        end else if (tick) begin
          if (cnt == LAST) begin
            state_n = IDLE_HI;
            cnt_n   = '0;
            level_n = 1'b1;
            press_n = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      IDLE_HI: if (!s) begin
        state_n = WAIT_LO;
        cnt_n   = '0;
      end
      WAIT_LO: begin
        if (s) begin
          state_n = IDLE_HI;
          cnt_n   = '0;
        end else if (tick) begin
          if (cnt == LAST) begin
            state_n   = IDLE_LO;
            cnt_n     = '0;
            level_n   = 1'b0;
            release_n = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE_LO;
        cnt_n   = '0;
      end
    endcase
  end

`ifdef LONG_PRESS_EN
  localparam int LW = $clog2(LONG_TICKS + 1);
  localparam logic [LW-1:0] LLAST = LW'(LONG_TICKS - 1);

  logic [LW-1:0] lcnt, lcnt_n;
  logic          fired, fired_n, long_n;

  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      lcnt       <= '0;
      fired      <= 1'b0;
      long_press <= 1'b0;
    end else begin
      lcnt       <= lcnt_n;
      fired      <= fired_n;
      long_press <= long_n;
    end
  end

  // fired keeps the saturated counter from pulsing twice per press.
  always_comb begin
    lcnt_n  = lcnt;
    fired_n = fired;
    long_n  = 1'b0;
    if (state != IDLE_HI || state_n != IDLE_HI) begin
      lcnt_n  = '0;
      fired_n = 1'b0;
    end else if (tick && !fired) begin
      if (lcnt == LLAST) begin
        long_n  = 1'b1;
        fired_n = 1'b1;
      end else begin
        lcnt_n = lcnt + 1'b1;
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce_fsm.sv
// Directed bench for btn_debounce_fsm: DEB_TICKS=4, LONG_TICKS=8,
// one tick every 10 clocks.
module tb_btn_debounce_fsm;

  logic clk_100Mhz = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic btn_raw = 1'b0;
  logic btn_level, btn_press, btn_release, long_press;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_100Mhz = ~clk_100Mhz;

  btn_debounce_fsm #(
    .DEB_TICKS   (4),
    .SYNC_STAGES (2),
    .LONG_TICKS  (8)
  ) dut (
    .clk_100Mhz  (clk_100Mhz),
    .rst         (rst),
    .tick        (tick),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .long_press  (long_press)
  );

  typedef struct {
    logic btn;
    int   clks;
    logic level;
    int   press;
    int   rel;
    int   lng;
  } vec_t;

  vec_t tbl[16];

  task automatic step();
    tick = (cyc % 10 == 0);
    @(posedge clk_100Mhz);
    #1;
    cyc++;
  endtask

  task automatic align();
    while (cyc % 10 != 0) step();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive btn_raw=val from a tick-aligned edge for n clocks and record
  // where the level settles, where the edge pulse lands and long presses.
  task automatic run_edge(
    input  logic val,
    input  int   n,
    output int   lvl_idx,
    output int   pls_idx,
    output int   npls,
    output int   nlong,
    output int   long_idx
  );
    lvl_idx  = -1;
    pls_idx  = -1;
    npls     = 0;
    nlong    = 0;
    long_idx = -1;
    align();
    btn_raw = val;
    for (int i = 0; i < n; i++) begin
      step();
      if (lvl_idx < 0 && btn_level == val) lvl_idx = i;
      if ((val && btn_press) || (!val && btn_release)) begin
        npls++;
        if (pls_idx < 0) pls_idx = i;
      end
      if (long_press) begin
        nlong++;
        if (long_idx < 0) long_idx = i;
      end
    end
  endtask

  initial begin
    int p, r, l, bad;
    int li, pi, np, nl, lgi;

    tbl[0]  = '{1'b0, 30,  1'b0, 0, 0, 0};
    tbl[1]  = '{1'b1, 100, 1'b1, 1, 0, 0};
    tbl[2]  = '{1'b0, 100, 1'b0, 0, 1, 0};
    tbl[3]  = '{1'b1, 15,  1'b0, 0, 0, 0};
    tbl[4]  = '{1'b0, 15,  1'b0, 0, 0, 0};
    tbl[5]  = '{1'b1, 15,  1'b0, 0, 0, 0};
    tbl[6]  = '{1'b0, 15,  1'b0, 0, 0, 0};
    tbl[7]  = '{1'b1, 15,  1'b0, 0, 0, 0};
    tbl[8]  = '{1'b0, 15,  1'b0, 0, 0, 0};
    tbl[9]  = '{1'b1, 100, 1'b1, 1, 0, 0};
    tbl[10] = '{1'b0, 15,  1'b1, 0, 0, 0};
    tbl[11] = '{1'b1, 15,  1'b1, 0, 0, 0};
    tbl[12] = '{1'b0, 15,  1'b1, 0, 0, 0};
    tbl[13] = '{1'b1, 15,  1'b1, 0, 0, 0};
    tbl[14] = '{1'b0, 100, 1'b0, 0, 1, 0};
    tbl[15] = '{1'b0, 20,  1'b0, 0, 0, 0};

    // Reset held with the button pressed: nothing may leak out.
    rst = 1'b1;
    btn_raw = 1'b1;
    bad = 0;
    #1;
    for (int i = 0; i < 40; i++) begin
      step();
      bad += btn_level + btn_press + btn_release + long_press;
    end
    chk("reset_outputs", bad, 0);
    btn_raw = 1'b0;
    step();
    rst = 1'b0;

    foreach (tbl[k]) begin
      btn_raw = tbl[k].btn;
      p = 0;
      r = 0;
      l = 0;
      for (int i = 0; i < tbl[k].clks; i++) begin
        step();
        p += btn_press;
        r += btn_release;
        l += long_press;
      end
      chk($sformatf("vec%0d_level", k), btn_level, tbl[k].level);
      chk($sformatf("vec%0d_press", k), p, tbl[k].press);
      chk($sformatf("vec%0d_release", k), r, tbl[k].rel);
      chk($sformatf("vec%0d_long", k), l, tbl[k].lng);
    end

    // Exact latency: sync 2 clks, WAIT entry 1 clk, accept on 4th tick.
    run_edge(1'b1, 100, li, pi, np, nl, lgi);
    chk("press_level_idx", li, 40);
    chk("press_pulse_idx", pi, 40);
    chk("press_pulse_cnt", np, 1);
    run_edge(1'b0, 100, li, pi, np, nl, lgi);
    chk("release_level_idx", li, 40);
    chk("release_pulse_idx", pi, 40);
    chk("release_pulse_cnt", np, 1);

    // Reset mid-WAIT_HI (cnt=2), button still held afterwards.
    align();
    btn_raw = 1'b1;
    for (int i = 0; i < 25; i++) step();
    rst = 1'b1;
    #1;
    chk("midrst_level", btn_level, 0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      bad += btn_level + btn_press + btn_release;
    end
    chk("midrst_quiet", bad, 0);
    align();
    rst = 1'b0;
    li = -1;
    pi = -1;
    np = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (li < 0 && btn_level) li = i;
      if (btn_press) begin
        np++;
        if (pi < 0) pi = i;
      end
    end
    chk("midrst_level_idx", li, 40);
    chk("midrst_press_idx", pi, 40);
    chk("midrst_press_cnt", np, 1);

    btn_raw = 1'b0;
    for (int i = 0; i < 100; i++) step();
    chk("midrst_released", btn_level, 0);

    // Long hold: long_press 8 ticks after the press, exactly once.
    run_edge(1'b1, 200, li, pi, np, nl, lgi);
    chk("long_press_idx", pi, 40);
`ifdef LONG_PRESS_EN
    chk("long_cnt", nl, 1);
    chk("long_idx", lgi, 120);
`else
    chk("long_cnt", nl, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
